uart_frame_loader: RTL and testbench

UART_FRAME_LOADER -- requirements
Module: uart_frame_loader

---
 rtl/uart_frame_loader.sv | 176 +++++++++++++++++
 tb/tb_uart_frame_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_loader.sv
// rtl/uart_frame_loader.sv - pairs UART bytes into 16-bit words and writes them to SDRAM
module uart_frame_loader #(
  parameter int FRAME_WORDS  = 19220,
  parameter int HADDR_WIDTH  = 24,
  parameter int IDLE_TIMEOUT = 2517500
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx_dv,
  input  logic [7:0]             rx_byte,
  input  logic                   restart,
  input  logic                   busy,
  output logic [HADDR_WIDTH-1:0] wr_addr,
  output logic [15:0]            wr_data,
  output logic                   wr_enable,
  output logic                   frame_done,
  output logic                   overrun,
  output logic [HADDR_WIDTH-1:0] word_count
);

  localparam logic [1:0] IDLE_LO = 2'd0;
  localparam logic [1:0] WAIT_HI = 2'd1;
  localparam logic [1:0] WRITE   = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam int TW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0]          TIMER_LAST = TW'(IDLE_TIMEOUT - 1);
  localparam logic [HADDR_WIDTH-1:0] LAST_WORD  = HADDR_WIDTH'(FRAME_WORDS);

  logic [1:0]             state_q, state_d;
  logic [7:0]             lo_byte_q, lo_byte_d;
  logic                   lo_valid_q, lo_valid_d;
  logic [15:0]            hold_data_q, hold_data_d;
  logic                   hold_valid_q, hold_valid_d;
  logic [HADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]            wr_data_q, wr_data_d;
  logic                   wr_en_q, wr_en_d;
  logic [HADDR_WIDTH-1:0] count_q, count_d;
  logic                   overrun_q, overrun_d;
  logic [TW-1:0]          timer_q, timer_d;

  logic                   word_done;
  logic                   accept;
  logic [15:0]            new_word;

  // Byte pairing, half-word timeout, write issue/accept and the one-word holding slot
  always_comb begin
    state_d      = state_q;
    lo_byte_d    = lo_byte_q;
    lo_valid_d   = lo_valid_q;
    hold_data_d  = hold_data_q;
    hold_valid_d = hold_valid_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_en_d      = wr_en_q;
    count_d      = count_q;
    overrun_d    = overrun_q;
    timer_d      = timer_q;
    word_done    = 1'b0;
    new_word     = {rx_byte, lo_byte_q};
    accept       = wr_en_q && !busy;

    if (restart) begin
      // A write accepted in this same cycle still completes on the bus but is not counted
      state_d      = IDLE_LO;
      lo_valid_d   = 1'b0;
      hold_valid_d = 1'b0;
      wr_en_d      = 1'b0;
      count_d      = '0;
      overrun_d    = 1'b0;
      timer_d      = '0;
    end else begin
      if (state_q != DONE) begin
        if (rx_dv) begin
          timer_d = '0;
          if (lo_valid_q) begin
            lo_valid_d = 1'b0;
            word_done  = 1'b1;
          end else begin
            lo_byte_d  = rx_byte;
            lo_valid_d = 1'b1;
          end
        end else if (lo_valid_q) begin
          if (timer_q == TIMER_LAST) begin
            lo_valid_d = 1'b0;
            timer_d    = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end

      case (state_q)
        IDLE_LO, WAIT_HI: begin
          if (word_done) begin
            wr_data_d = new_word;
            wr_addr_d = count_q;
            wr_en_d   = 1'b1;
            state_d   = WRITE;
          end else begin
            state_d = lo_valid_d ? WAIT_HI : IDLE_LO;
          end
        end
        WRITE: begin
          if (accept) begin
            count_d = (count_q == LAST_WORD) ? count_q : count_q + 1'b1;
            if (count_d == LAST_WORD) begin
              state_d      = DONE;
              wr_en_d      = 1'b0;
              hold_valid_d = 1'b0;
              lo_valid_d   = 1'b0;
            end else if (hold_valid_q) begin
              // Held word goes straight out; a word finishing now refills the slot
              wr_data_d    = hold_data_q;
              wr_addr_d    = count_d;
              hold_valid_d = word_done;
              hold_data_d  = new_word;
            end else if (word_done) begin
              wr_data_d = new_word;
              wr_addr_d = count_d;
            end else begin
              wr_en_d = 1'b0;
              state_d = lo_valid_d ? WAIT_HI : IDLE_LO;
            end
          end else if (word_done) begin
            if (!hold_valid_q) begin
              hold_valid_d = 1'b1;
              hold_data_d  = new_word;
            end else begin
              overrun_d = 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE_LO;
      lo_byte_q    <= '0;
      lo_valid_q   <= 1'b0;
      hold_data_q  <= '0;
      hold_valid_q <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_en_q      <= 1'b0;
      count_q      <= '0;
      overrun_q    <= 1'b0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      lo_byte_q    <= lo_byte_d;
      lo_valid_q   <= lo_valid_d;
      hold_data_q  <= hold_data_d;
      hold_valid_q <= hold_valid_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_en_q      <= wr_en_d;
      count_q      <= count_d;
      overrun_q    <= overrun_d;
      timer_q      <= timer_d;
    end
  end

  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign wr_enable  = wr_en_q;
  assign frame_done = (state_q == DONE);
  assign overrun    = overrun_q;
  assign word_count = count_q;

endmodule

// File: tb/tb_uart_frame_loader.sv
// tb/tb_uart_frame_loader.sv - directed self-checking bench for uart_frame_loader
module tb_uart_frame_loader;

  localparam int FW = 4;
  localparam int AW = 8;
  localparam int TO = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_dv = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic          restart = 1'b0;
  logic          busy = 1'b0;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          wr_enable;
  logic          frame_done;
  logic          overrun;
  logic [AW-1:0] word_count;

  int pass_n = 0;
  int total_n = 0;

  logic [AW-1:0] acc_addr [0:63];
  logic [15:0]   acc_data [0:63];
  int            acc_n = 0;
  int            base;

  uart_frame_loader #(.FRAME_WORDS(FW), .HADDR_WIDTH(AW), .IDLE_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_dv(rx_dv), .rx_byte(rx_byte), .restart(restart),
    .busy(busy), .wr_addr(wr_addr), .wr_data(wr_data), .wr_enable(wr_enable),
    .frame_done(frame_done), .overrun(overrun), .word_count(word_count)
  );

  always #5 clk = ~clk;

  // Record every write the bus accepts
  always @(posedge clk) begin
    if (rst_n && wr_enable && !busy) begin
      if (acc_n < 64) begin
        acc_addr[acc_n] = wr_addr;
        acc_data[acc_n] = wr_data;
      end
      acc_n = acc_n + 1;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_dv = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv = 1'b0;
  endtask

  task automatic pulse_restart();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total_n++; if (wr_enable !== 1'b0) $display("FAIL reset_wr_enable got=%0b exp=0", wr_enable); else pass_n++;
    total_n++; if (wr_addr !== 8'h00) $display("FAIL reset_wr_addr got=%0h exp=0", wr_addr); else pass_n++;
    total_n++; if (wr_data !== 16'h0000) $display("FAIL reset_wr_data got=%0h exp=0", wr_data); else pass_n++;
    total_n++; if ({frame_done, overrun} !== 2'b00) $display("FAIL reset_flags got=%0b exp=00", {frame_done, overrun}); else pass_n++;
    total_n++; if (word_count !== 8'h00) $display("FAIL reset_word_count got=%0d exp=0", word_count); else pass_n++;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    send_byte(8'h34);
    send_byte(8'h12);
    total_n++; if (wr_enable !== 1'b1) $display("FAIL basic_wr_enable got=%0b exp=1", wr_enable); else pass_n++;
    total_n++; if (wr_data !== 16'h1234) $display("FAIL basic_wr_data got=%0h exp=1234", wr_data); else pass_n++;
    total_n++; if (wr_addr !== 8'h00) $display("FAIL basic_wr_addr got=%0h exp=0", wr_addr); else pass_n++;
    @(negedge clk);
    total_n++; if (wr_enable !== 1'b0) $display("FAIL basic_wr_enable_drop got=%0b exp=0", wr_enable); else pass_n++;
    total_n++; if (word_count !== 8'd1) $display("FAIL basic_word_count got=%0d exp=1", word_count); else pass_n++;
  endtask

  task automatic test_busy();
    busy = 1'b1;
    send_byte(8'h78);
    send_byte(8'h56);
    base = acc_n;
    for (int i = 0; i < 10; i++) begin
      total_n++;
      if (wr_enable !== 1'b1 || wr_data !== 16'h5678)
        $display("FAIL busy_hold_%0d got=en%0b/%0h exp=en1/5678", i, wr_enable, wr_data);
      else pass_n++;
      @(negedge clk);
    end
    busy = 1'b0;
    @(negedge clk);
    total_n++; if (acc_n - base !== 1) $display("FAIL busy_accepts got=%0d exp=1", acc_n - base); else pass_n++;
    total_n++; if (acc_addr[base] !== 8'd1) $display("FAIL busy_addr got=%0d exp=1", acc_addr[base]); else pass_n++;
    total_n++; if (wr_enable !== 1'b0) $display("FAIL busy_wr_enable_drop got=%0b exp=0", wr_enable); else pass_n++;
    total_n++; if (word_count !== 8'd2) $display("FAIL busy_word_count got=%0d exp=2", word_count); else pass_n++;
  endtask

  task automatic test_overrun();
    pulse_restart();
    busy = 1'b1;
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h02); send_byte(8'h00);
    total_n++; if (overrun !== 1'b0) $display("FAIL ovr_early got=%0b exp=0", overrun); else pass_n++;
    send_byte(8'h03); send_byte(8'h00);
    total_n++; if (overrun !== 1'b1) $display("FAIL ovr_flag got=%0b exp=1", overrun); else pass_n++;
    base = acc_n;
    busy = 1'b0;
    repeat (4) @(negedge clk);
    total_n++; if (acc_n - base !== 2) $display("FAIL ovr_accepts got=%0d exp=2", acc_n - base); else pass_n++;
    total_n++;
    if (acc_addr[base] !== 8'd0 || acc_data[base] !== 16'h0001)
      $display("FAIL ovr_word1 got=%0d/%0h exp=0/0001", acc_addr[base], acc_data[base]);
    else pass_n++;
    total_n++;
    if (acc_addr[base+1] !== 8'd1 || acc_data[base+1] !== 16'h0002)
      $display("FAIL ovr_word2 got=%0d/%0h exp=1/0002", acc_addr[base+1], acc_data[base+1]);
    else pass_n++;
    total_n++; if (word_count !== 8'd2) $display("FAIL ovr_word_count got=%0d exp=2", word_count); else pass_n++;
    total_n++; if (overrun !== 1'b1) $display("FAIL ovr_sticky got=%0b exp=1", overrun); else pass_n++;
  endtask

  task automatic test_frame_done();
    pulse_restart();
    total_n++; if (overrun !== 1'b0) $display("FAIL fd_overrun_cleared got=%0b exp=0", overrun); else pass_n++;
    base = acc_n;
    for (int i = 0; i < 10; i++) send_byte(8'h10 + 8'(i));
    repeat (2) @(negedge clk);
    total_n++; if (frame_done !== 1'b1) $display("FAIL fd_flag got=%0b exp=1", frame_done); else pass_n++;
    total_n++; if (word_count !== 8'd4) $display("FAIL fd_word_count got=%0d exp=4", word_count); else pass_n++;
    total_n++; if (acc_n - base !== 4) $display("FAIL fd_accepts got=%0d exp=4", acc_n - base); else pass_n++;
    total_n++;
    if (acc_addr[base+3] !== 8'd3 || acc_data[base+3] !== 16'h1716)
      $display("FAIL fd_last_word got=%0d/%0h exp=3/1716", acc_addr[base+3], acc_data[base+3]);
    else pass_n++;
    total_n++; if (wr_enable !== 1'b0) $display("FAIL fd_wr_enable got=%0b exp=0", wr_enable); else pass_n++;
  endtask

  task automatic test_timeout();
    pulse_restart();
    total_n++; if (frame_done !== 1'b0) $display("FAIL to_frame_done_cleared got=%0b exp=0", frame_done); else pass_n++;
    send_byte(8'hAA);
    repeat (TO + 5) @(negedge clk);
    send_byte(8'h01);
    send_byte(8'h02);
    total_n++; if (wr_enable !== 1'b1) $display("FAIL to_wr_enable got=%0b exp=1", wr_enable); else pass_n++;
    total_n++; if (wr_data !== 16'h0201) $display("FAIL to_wr_data got=%0h exp=0201", wr_data); else pass_n++;
    total_n++; if (wr_addr !== 8'd0) $display("FAIL to_wr_addr got=%0d exp=0", wr_addr); else pass_n++;
    @(negedge clk);
    send_byte(8'h55);
    repeat (TO - 5) @(negedge clk);
    send_byte(8'h66);
    total_n++; if (wr_data !== 16'h6655) $display("FAIL to_short_gap_data got=%0h exp=6655", wr_data); else pass_n++;
    total_n++; if (wr_addr !== 8'd1) $display("FAIL to_short_gap_addr got=%0d exp=1", wr_addr); else pass_n++;
    @(negedge clk);
  endtask

  task automatic test_restart_collision();
    pulse_restart();
    send_byte(8'h11);
    send_byte(8'h22);
    @(negedge clk);
    send_byte(8'h33);
    @(negedge clk);
    restart = 1'b1;
    rx_dv = 1'b1;
    rx_byte = 8'h44;
    @(negedge clk);
    restart = 1'b0;
    rx_dv = 1'b0;
    total_n++; if (word_count !== 8'd0) $display("FAIL col_word_count got=%0d exp=0", word_count); else pass_n++;
    total_n++; if ({frame_done, overrun, wr_enable} !== 3'b000) $display("FAIL col_flags got=%0b exp=000", {frame_done, overrun, wr_enable}); else pass_n++;
    send_byte(8'h56);
    send_byte(8'h78);
    total_n++; if (wr_data !== 16'h7856) $display("FAIL col_wr_data got=%0h exp=7856", wr_data); else pass_n++;
    total_n++; if (wr_addr !== 8'd0) $display("FAIL col_wr_addr got=%0d exp=0", wr_addr); else pass_n++;
    @(negedge clk);
  endtask

  task automatic test_restart_in_write();
    pulse_restart();
    send_byte(8'h9A);
    send_byte(8'hBC);
    base = acc_n;
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    total_n++; if (acc_n - base !== 1) $display("FAIL rw_accepts got=%0d exp=1", acc_n - base); else pass_n++;
    total_n++; if (acc_data[base] !== 16'hBC9A) $display("FAIL rw_data got=%0h exp=bc9a", acc_data[base]); else pass_n++;
    total_n++; if (word_count !== 8'd0) $display("FAIL rw_word_count got=%0d exp=0", word_count); else pass_n++;
    total_n++; if (wr_enable !== 1'b0) $display("FAIL rw_wr_enable got=%0b exp=0", wr_enable); else pass_n++;
    send_byte(8'h01);
    send_byte(8'h02);
    total_n++; if (wr_addr !== 8'd0) $display("FAIL rw_next_addr got=%0d exp=0", wr_addr); else pass_n++;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    busy = 1'b1;
    send_byte(8'hEF);
    send_byte(8'hCD);
    total_n++; if (wr_enable !== 1'b1) $display("FAIL ar_wr_enable_before got=%0b exp=1", wr_enable); else pass_n++;
    #2;
    rst_n = 1'b0;
    #1;
    total_n++; if (wr_enable !== 1'b0) $display("FAIL ar_wr_enable_async got=%0b exp=0", wr_enable); else pass_n++;
    total_n++; if (word_count !== 8'd0) $display("FAIL ar_word_count got=%0d exp=0", word_count); else pass_n++;
    @(negedge clk);
    rst_n = 1'b1;
    busy = 1'b0;
    send_byte(8'h21);
    send_byte(8'h43);
    total_n++; if (wr_data !== 16'h4321) $display("FAIL ar_first_word got=%0h exp=4321", wr_data); else pass_n++;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_busy();
    test_overrun();
    test_frame_done();
    test_timeout();
    test_restart_collision();
    test_restart_in_write();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
